tile_map_ram: RTL and testbench

- Parametrised, writable tile-map store: a 2^MAP_W_BITS × 2^MAP_H_BITS grid of DATA_W-bit tile entries.
- The draw pipeline reads it by tile (x, y) with wrap-around. A host-side write port updates it with byte enables.
- A built-in fill engine clears or initialises the whole map in hardware.
- Sits between the tile renderer's fetch stage and the future memory/host interface.

---
 rtl/tile_map_ram.sv | 180 ++++++++++++++++++
 tb/tb_tile_map_ram.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_ram.sv
// tile_map_ram: writable 2^MAP_W_BITS x 2^MAP_H_BITS tile-map store.
//   Read port  : rd_en/rd_x/rd_y -> rd_valid/rd_data. Coordinates wrap, and
//                the port is fully pipelined with a latency of 1 (OUT_REG=0)
//                or 2 (OUT_REG=1) cycles. Reads are write-first against a
//                same-cycle host write.
//   Write port : wr_en/wr_addr/wr_data/wr_be. The linear address is {y, x}.
//                Writes are byte-enabled, and they are dropped while busy.
//   Fill engine: fill_req/fill_value start a whole-map fill, one entry per
//                cycle. busy is high while the fill runs, and fill_done
//                pulses for one cycle at the end.
//   Clock/reset: clk_draw, rst_draw_n (async assert, active low).
module tile_map_ram #(
  parameter int    MAP_W_BITS = 5,
  parameter int    MAP_H_BITS = 5,
  parameter int    DATA_W     = 16,
  parameter int    OUT_REG    = 0,
  parameter string FILENAME   = ""
) (
  input  logic                             clk_draw,
  input  logic                             rst_draw_n,
  input  logic                             rd_en,
  input  logic [15:0]                      rd_x,
  input  logic [15:0]                      rd_y,
  output logic                             rd_valid,
  output logic [DATA_W-1:0]                rd_data,
  input  logic                             wr_en,
  input  logic [MAP_W_BITS+MAP_H_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic [DATA_W/8-1:0]              wr_be,
  input  logic                             fill_req,
  input  logic [DATA_W-1:0]                fill_value,
  output logic                             busy,
  output logic                             fill_done
);
  localparam int AW    = MAP_W_BITS + MAP_H_BITS;
  localparam int DEPTH = 1 << AW;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     fill_cnt, fill_cnt_nxt;
  logic [DATA_W-1:0] fill_val_q;
  logic              fill_done_nxt;
  logic              fill_start;

  always_comb begin
    state_nxt     = state;
    fill_cnt_nxt  = fill_cnt;
    fill_done_nxt = 1'b0;
    fill_start    = 1'b0;
    case (state)
      IDLE: begin
        if (fill_req) begin
          state_nxt    = FILL;
          fill_cnt_nxt = '0;
          fill_start   = 1'b1;
        end
      end
      FILL: begin
        fill_cnt_nxt = fill_cnt + 1'b1;
        if (fill_cnt == '1) begin
          state_nxt     = IDLE;
          fill_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state      <= IDLE;
      fill_cnt   <= '0;
      fill_val_q <= '0;
      fill_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_cnt_nxt;
      fill_done <= fill_done_nxt;
      if (fill_start) fill_val_q <= fill_value;
    end
  end

  assign busy = (state == FILL);

  // Single write port shared by the fill engine and the host.
  logic              host_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_wbe;

  assign host_we = wr_en && (state == IDLE) && (|wr_be);

  always_comb begin
    if (state == FILL) begin
      mem_waddr = fill_cnt;
      mem_wdata = fill_val_q;
      mem_wbe   = '1;
    end else begin
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      mem_wbe   = host_we ? wr_be : '0;
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_draw) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (mem_wbe[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // The array itself is read-first. Write-first behaviour comes from
  // registering the colliding host bytes and merging them after the RAM.
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] byp_mask_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] merged;
  logic              rd_v1;
  logic              unused_rd_hi;

  assign rd_addr      = {rd_y[MAP_H_BITS-1:0], rd_x[MAP_W_BITS-1:0]};
  assign unused_rd_hi = ^{rd_x[15:MAP_W_BITS], rd_y[15:MAP_H_BITS]};

  always_ff @(posedge clk_draw) begin
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_comb begin
    be_mask = '0;
    for (int unsigned i = 0; i < NB; i++) be_mask[8*i +: 8] = {8{wr_be[i]}};
  end

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      rd_v1      <= 1'b0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else begin
      rd_v1 <= rd_en;
      if (rd_en) begin
        byp_mask_q <= (host_we && (wr_addr == rd_addr)) ? be_mask : '0;
        byp_data_q <= wr_data;
      end
    end
  end

  assign merged = (ram_q & ~byp_mask_q) | (byp_data_q & byp_mask_q);

  if (OUT_REG == 0) begin : g_lat1
    // ram_q has no reset. have_data forces rd_data to zero until the first
    // read after reset.
    logic have_data;
    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
      if (!rst_draw_n) have_data <= 1'b0;
      else if (rd_en)  have_data <= 1'b1;
    end
    assign rd_valid = rd_v1;
    assign rd_data  = have_data ? merged : '0;
  end else begin : g_lat2
    logic              rd_v2;
    logic [DATA_W-1:0] rd_data_q;
    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
      if (!rst_draw_n) begin
        rd_v2     <= 1'b0;
        rd_data_q <= '0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) rd_data_q <= merged;
      end
    end
    assign rd_valid = rd_v2;
    assign rd_data  = rd_data_q;
  end

endmodule

// File: tb/tb_tile_map_ram.sv
// tb_tile_map_ram: runs two tile_map_ram instances (OUT_REG=0 and OUT_REG=1)
// against a behavioural map model. Directed scenarios are followed by
// randomized traffic.
module tb_tile_map_ram;
  localparam int MW    = 5;
  localparam int MH    = 5;
  localparam int MAP_W = 1 << MW;
  localparam int MAP_H = 1 << MH;
  localparam int DEPTH = MAP_W * MAP_H;
  localparam int NB    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rd_en, wr_en, fill_req;
  logic [15:0] rd_x, rd_y, wr_data, fill_value;
  logic [9:0]  wr_addr;
  logic [1:0]  wr_be;
  logic        v0, v1, busy0, busy1, done0, done1;
  logic [15:0] d0, d1;

  tile_map_ram #(.MAP_W_BITS(MW), .MAP_H_BITS(MH), .DATA_W(16), .OUT_REG(0)) u_lat1 (
    .clk_draw(clk), .rst_draw_n(rst_n), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(v0), .rd_data(d0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .fill_req(fill_req), .fill_value(fill_value), .busy(busy0),
    .fill_done(done0));

  tile_map_ram #(.MAP_W_BITS(MW), .MAP_H_BITS(MH), .DATA_W(16), .OUT_REG(1)) u_lat2 (
    .clk_draw(clk), .rst_draw_n(rst_n), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(v1), .rd_data(d1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .fill_req(fill_req), .fill_value(fill_value), .busy(busy1),
    .fill_done(done1));

  int vectors = 0;
  int miscompares = 0;
  int bcnt = 0;
  int dcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] addr_of(input logic [15:0] x, input logic [15:0] y);
    return 10'((int'(y) % MAP_H) * MAP_W + (int'(x) % MAP_W));
  endfunction

  // Behavioural model: map contents, fill progress and expected outputs.
  logic [15:0] mmem [DEPTH];
  bit          fill_act = 0;
  int          fidx = 0;
  logic [15:0] fval = '0;
  bit          exp_done = 0;
  bit          e0v = 0, s1v = 0, e1v = 0;
  logic [15:0] e0d = '0, s1d = '0, e1d = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      fill_act = 0; fidx = 0; exp_done = 0;
      e0v = 0; e0d = '0; s1v = 0; s1d = '0; e1v = 0; e1d = '0;
    end else begin
      bit          rv;
      logic [15:0] rw;
      rv = rd_en;
      rw = '0;
      if (wr_en && !fill_act)
        for (int b = 0; b < NB; b++)
          if (wr_be[b]) mmem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      if (rv) rw = mmem[addr_of(rd_x, rd_y)];
      exp_done = 0;
      if (fill_act) begin
        mmem[fidx] = fval;
        fidx++;
        if (fidx == DEPTH) begin
          fill_act = 0;
          exp_done = 1;
        end
      end else if (fill_req) begin
        fill_act = 1; fidx = 0; fval = fill_value;
      end
      e1v = s1v; if (s1v) e1d = s1d;
      s1v = rv;  if (rv)  s1d = rw;
      e0v = rv;  if (rv)  e0d = rw;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("valid_l1", v0, e0v);
      chk("data_l1", d0, e0d);
      chk("valid_l2", v1, e1v);
      chk("data_l2", d1, e1d);
      chk("busy_l1", busy0, fill_act);
      chk("busy_l2", busy1, fill_act);
      chk("done_l1", done0, exp_done);
      chk("done_l2", done1, exp_done);
      if (busy0) bcnt++;
      if (done0) dcnt++;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
    cyc();
    wr_en = 0;
  endtask

  task automatic rd_lit(input string nm, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] exp);
    rd_en = 1; rd_x = x; rd_y = y;
    cyc();
    rd_en = 0;
    chk({nm, "_v_l1"}, v0, 1);
    chk({nm, "_d_l1"}, d0, exp);
    cyc();
    chk({nm, "_v_l2"}, v1, 1);
    chk({nm, "_d_l2"}, d1, exp);
  endtask

  bit          pat  [4] = '{1, 1, 0, 1};
  logic [15:0] px   [4] = '{16'd1, 16'd31, 16'd0, 16'd0};
  logic [15:0] py   [4] = '{16'd2, 16'd2, 16'd0, 16'd8};
  logic [15:0] pexp [4] = '{16'hBEEF, 16'h1F1F, 16'h0000, 16'hAB34};

  initial begin
    int b0, dc0;
    rd_en = 0; rd_x = 0; rd_y = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
    fill_req = 0; fill_value = 0;
    repeat (3) cyc();
    chk("rst_valid_l1", v0, 0);
    chk("rst_data_l1", d0, 0);
    chk("rst_valid_l2", v1, 0);
    chk("rst_data_l2", d1, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    #2 rst_n = 1;
    cyc();

    // Clear the map so every entry is known.
    b0 = bcnt; dc0 = dcnt;
    fill_req = 1; fill_value = 16'h0000;
    cyc();
    fill_req = 0;
    repeat (DEPTH + 4) cyc();
    chk("clear_busy_len", bcnt - b0, DEPTH);
    chk("clear_done_cnt", dcnt - dc0, 1);

    wr(10'h041, 16'hBEEF, 2'b11);
    rd_lit("basic", 16'd1, 16'd2, 16'hBEEF);
    rd_lit("wrap", 16'd33, 16'd34, 16'hBEEF);
    wr(10'd95, 16'h1F1F, 2'b11);
    rd_lit("wrapx", 16'hFFFF, 16'd2, 16'h1F1F);
    wr(10'h100, 16'h1234, 2'b11);
    wr(10'h100, 16'h5555, 2'b00);

    // Byte-enabled write and a read of the same address in the same cycle.
    wr_en = 1; wr_addr = 10'h100; wr_data = 16'hABCD; wr_be = 2'b10;
    rd_en = 1; rd_x = 16'd0; rd_y = 16'd8;
    cyc();
    wr_en = 0; rd_en = 0;
    chk("wfirst_v_l1", v0, 1);
    chk("wfirst_d_l1", d0, 16'hAB34);
    cyc();
    chk("wfirst_d_l2", d1, 16'hAB34);
    rd_lit("be_hold", 16'd0, 16'd8, 16'hAB34);

    // Gapped back-to-back reads through the 2-cycle pipeline.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        rd_en = pat[i]; rd_x = px[i]; rd_y = py[i];
      end else rd_en = 0;
      cyc();
      if (i >= 1 && i <= 4) begin
        chk("gap_v_l2", v1, pat[i-1]);
        if (pat[i-1]) chk("gap_d_l2", d1, pexp[i-1]);
      end
    end
    rd_en = 0;

    // Reset in the middle of a fill, after 100 entries have been written.
    wr(10'd500, 16'h5A5A, 2'b11);
    b0 = bcnt; dc0 = dcnt;
    fill_req = 1; fill_value = 16'h0007;
    cyc();
    fill_req = 0;
    repeat (100) cyc();
    #2 rst_n = 0;
    #1;
    chk("midrst_busy_l1", busy0, 0);
    chk("midrst_busy_l2", busy1, 0);
    chk("midrst_done", done0, 0);
    cyc();
    cyc();
    #2 rst_n = 1;
    cyc();
    chk("midrst_no_done", dcnt - dc0, 0);
    chk("midrst_busy_len", bcnt - b0, 101);
    rd_lit("midrst_a0", 16'd0, 16'd0, 16'h0007);
    rd_lit("midrst_a99", 16'd3, 16'd3, 16'h0007);
    rd_lit("midrst_a100", 16'd4, 16'd3, 16'h0000);
    rd_lit("midrst_a500", 16'd20, 16'd15, 16'h5A5A);

    // Full fill: a host write and a second fill_req arrive mid-fill.
    b0 = bcnt; dc0 = dcnt;
    fill_req = 1; fill_value = 16'h0007;
    cyc();
    fill_req = 0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      wr_en = (c == 200); wr_addr = 10'd5; wr_data = 16'hFFFF; wr_be = 2'b11;
      fill_req = (c == 300); fill_value = 16'h1111;
      rd_en = (c % 7 == 0); rd_x = 16'($urandom); rd_y = 16'($urandom);
      cyc();
    end
    wr_en = 0; fill_req = 0; rd_en = 0;
    chk("fill_busy_len", bcnt - b0, DEPTH);
    chk("fill_done_cnt", dcnt - dc0, 1);
    rd_lit("fill_a0", 16'd0, 16'd0, 16'h0007);
    rd_lit("fill_a1023", 16'd31, 16'd31, 16'h0007);
    rd_lit("fill_dropped_wr", 16'd5, 16'd0, 16'h0007);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      rd_en = ($urandom_range(0, 9) < 6);
      rd_x = 16'($urandom); rd_y = 16'($urandom);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = ($urandom_range(0, 2) == 0) ? addr_of(rd_x, rd_y) : 10'($urandom);
      wr_data = 16'($urandom); wr_be = 2'($urandom);
      fill_req = ($urandom_range(0, 999) == 0); fill_value = 16'($urandom);
      cyc();
    end
    rd_en = 0; wr_en = 0; fill_req = 0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
